// File: rtl/tawas_raccoon_arb.sv
// tawas_raccoon_arb
// Four-requester arbiter onto the Raccoon ring. Each requester owns one slot
// that captures a word request, issues it onto the ring (round-robin among
// ready slots, yielding to forwarded ring traffic), waits for an ack or a
// retry from the far side, backs off on retry, and times out if nothing
// returns. Completions are reported as a one-hot pulse on RSP_VLD.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   REQ_VLD/REQ_RDY     per-requester handshake (bit i = requester i)
//   REQ_ADDR[71:0]      four 18-bit word addresses
//   REQ_MASK[15:0]      four byte masks (0 = read)
//   REQ_DATA[127:0]     four 32-bit write words
//   RSP_VLD[3:0]        one-hot completion pulse
//   RSP_DATA[31:0]      read data (0 for writes and errors)
//   RSP_ERR             completion was a retry exhaustion or timeout
//   RaccOut[63:0]       registered ring output
//   RaccIn[63:0]        ring input (registered before use)
module tawas_raccoon_arb #(
  parameter logic [5:0] ID_UPPER  = 6'd0,
  parameter logic [3:0] RETRY_MAX = 4'd7,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [3:0]   REQ_VLD,
  output logic [3:0]   REQ_RDY,
  input  logic [71:0]  REQ_ADDR,
  input  logic [15:0]  REQ_MASK,
  input  logic [127:0] REQ_DATA,
  output logic [3:0]   RSP_VLD,
  output logic [31:0]  RSP_DATA,
  output logic         RSP_ERR,
  output logic [63:0]  RaccOut,
  input  logic [63:0]  RaccIn
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READY_TX = 3'd1,
    S_SENT     = 3'd2,
    S_BACKOFF  = 3'd3,
    S_DONE     = 3'd4
  } slot_state_e;

  slot_state_e state_r [4];
  slot_state_e state_s [4];
  logic [17:0] addr_r  [4];
  logic [17:0] addr_s  [4];
  logic [3:0]  mask_r  [4];
  logic [3:0]  mask_s  [4];
  logic [31:0] data_r  [4];
  logic [31:0] data_s  [4];
  logic [3:0]  retry_r [4];
  logic [3:0]  retry_s [4];
  logic [1:0]  bo_r    [4];
  logic [1:0]  bo_s    [4];
  logic [7:0]  to_r    [4];
  logic [7:0]  to_s    [4];

  logic [1:0]  ptr_r, ptr_s;
  logic [63:0] racc_in_r;
  logic [63:0] racc_out_r, racc_out_s;
  logic [3:0]  rdy_r, rdy_s;
  logic [3:0]  rsp_vld_r, rsp_vld_s;
  logic [31:0] rsp_data_r, rsp_data_s;
  logic        rsp_err_r, rsp_err_s;

  logic        fwd_s;
  logic        own_evt_s;
  logic [1:0]  in_idx_s;

  assign in_idx_s  = racc_in_r[55:54];
  assign fwd_s     = racc_in_r[63] && (racc_in_r[61:56] != ID_UPPER);
  // Packets carrying our own ID are consumed here, but only act on a slot
  // that is actually waiting; stale acks/retries fall on the floor.
  assign own_evt_s = racc_in_r[63] && (racc_in_r[61:56] == ID_UPPER) &&
                     (state_r[in_idx_s] == S_SENT);

  // Slot FSMs, ring issue/forward selection and completion reporting
  always_comb begin
    logic [1:0] cand;
    logic [1:0] gnt;
    logic       found;
    cand  = 2'd0;
    gnt   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      state_s[i] = state_r[i];
      addr_s[i]  = addr_r[i];
      mask_s[i]  = mask_r[i];
      data_s[i]  = data_r[i];
      retry_s[i] = retry_r[i];
      bo_s[i]    = bo_r[i];
      to_s[i]    = to_r[i];
    end
    ptr_s      = ptr_r;
    racc_out_s = 64'd0;
    rsp_vld_s  = 4'd0;
    rsp_data_s = 32'd0;
    rsp_err_s  = 1'b0;

    for (int i = 0; i < 4; i++) begin
      case (state_r[i])
        S_IDLE: begin
          if (REQ_VLD[i]) begin
            addr_s[i]  = REQ_ADDR[18*i +: 18];
            mask_s[i]  = REQ_MASK[4*i +: 4];
            data_s[i]  = REQ_DATA[32*i +: 32];
            retry_s[i] = 4'd0;
            state_s[i] = S_READY_TX;
          end else begin
            state_s[i] = S_IDLE;
          end
        end
        S_READY_TX: state_s[i] = S_READY_TX;
        S_SENT: begin
          if (to_r[i] != 8'hFF) begin
            to_s[i] = to_r[i] + 8'd1;
          end else begin
            to_s[i] = to_r[i];
          end
        end
        S_BACKOFF: begin
          if (bo_r[i] == 2'd3) begin
            bo_s[i]    = 2'd0;
            state_s[i] = S_READY_TX;
          end else begin
            bo_s[i] = bo_r[i] + 2'd1;
          end
        end
        S_DONE:  state_s[i] = S_IDLE;
        default: state_s[i] = S_IDLE;
      endcase
    end

    if (own_evt_s) begin
      if (!racc_in_r[62]) begin
        state_s[in_idx_s] = S_DONE;
        rsp_vld_s  = 4'd1 << in_idx_s;
        rsp_data_s = (mask_r[in_idx_s] == 4'd0) ? racc_in_r[31:0] : 32'd0;
      end else if (retry_r[in_idx_s] < RETRY_MAX) begin
        retry_s[in_idx_s] = retry_r[in_idx_s] + 4'd1;
        bo_s[in_idx_s]    = 2'd0;
        state_s[in_idx_s] = S_BACKOFF;
      end else begin
        state_s[in_idx_s] = S_DONE;
        rsp_vld_s = 4'd1 << in_idx_s;
        rsp_err_s = 1'b1;
      end
    end else begin
      rsp_vld_s = 4'd0;
    end

    // Timeouts report at most one per cycle; a slot that loses the response
    // port keeps its saturated counter and reports on a later cycle.
    for (int i = 0; i < 4; i++) begin
      if ((state_r[i] == S_SENT) && !(own_evt_s && (in_idx_s == i[1:0])) &&
          (rsp_vld_s == 4'd0) && (to_r[i] >= (TIMEOUT - 8'd1))) begin
        state_s[i] = S_DONE;
        rsp_vld_s  = 4'd1 << i;
        rsp_err_s  = 1'b1;
      end else begin
        state_s[i] = state_s[i];
      end
    end

    if (fwd_s) begin
      racc_out_s = racc_in_r;
    end else begin
      for (int k = 0; k < 4; k++) begin
        cand = ptr_r + k[1:0];
        if (!found && (state_r[cand] == S_READY_TX)) begin
          found = 1'b1;
          gnt   = cand;
        end else begin
          found = found;
        end
      end
      if (found) begin
        state_s[gnt] = S_SENT;
        to_s[gnt]    = 8'd0;
        racc_out_s   = {2'b11, ID_UPPER, gnt, mask_r[gnt], addr_r[gnt], data_r[gnt]};
        ptr_s        = gnt + 2'd1;
      end else begin
        racc_out_s = 64'd0;
      end
    end

    for (int i = 0; i < 4; i++) begin
      rdy_s[i] = (state_s[i] == S_IDLE);
    end
  end

  // State, counters and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        state_r[i] <= S_IDLE;
        addr_r[i]  <= 18'd0;
        mask_r[i]  <= 4'd0;
        data_r[i]  <= 32'd0;
        retry_r[i] <= 4'd0;
        bo_r[i]    <= 2'd0;
        to_r[i]    <= 8'd0;
      end
      ptr_r      <= 2'd0;
      racc_in_r  <= 64'd0;
      racc_out_r <= 64'd0;
      rdy_r      <= 4'b1111;
      rsp_vld_r  <= 4'd0;
      rsp_data_r <= 32'd0;
      rsp_err_r  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_r[i] <= state_s[i];
        addr_r[i]  <= addr_s[i];
        mask_r[i]  <= mask_s[i];
        data_r[i]  <= data_s[i];
        retry_r[i] <= retry_s[i];
        bo_r[i]    <= bo_s[i];
        to_r[i]    <= to_s[i];
      end
      ptr_r      <= ptr_s;
      racc_in_r  <= RaccIn;
      racc_out_r <= racc_out_s;
      rdy_r      <= rdy_s;
      rsp_vld_r  <= rsp_vld_s;
      rsp_data_r <= rsp_data_s;
      rsp_err_r  <= rsp_err_s;
    end
  end

  assign REQ_RDY  = rdy_r;
  assign RSP_VLD  = rsp_vld_r;
  assign RSP_DATA = rsp_data_r;
  assign RSP_ERR  = rsp_err_r;
  assign RaccOut  = racc_out_r;

endmodule
